// File: rtl/layer_sequencer.sv
// Address/strobe sequencer for one fully-connected layer: walks every (neuron, input)
// pair, steps the MAC datapath and writes each neuron's result to the output buffer.
module layer_sequencer #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 4,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] in_addr,
    output logic [AW-1:0] w_addr,
    output logic          rd_en,
    output logic          mac_clr,
    output logic          mac_en,
    output logic [AW-1:0] out_addr,
    output logic          out_wr,
    output logic          busy,
    output logic          done,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] j_q, j_d;
    logic [AW-1:0] wptr_q, wptr_d;

    logic [AW-1:0] in_addr_q, w_addr_q, out_addr_q;
    logic          rd_en_q, mac_clr_q, mac_en_q, out_wr_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        wptr_d  = wptr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    i_d     = '0;
                    j_d     = '0;
                    wptr_d  = '0;
                end
            end
            CLEAR: begin
                i_d     = '0;
                state_d = FETCH;
            end
            FETCH: begin
                // wptr also advances on the last input so the next neuron starts in place
                wptr_d = wptr_q + 1'b1;
                if (i_q == AW'(N_IN - 1)) begin
                    state_d = DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DRAIN: state_d = WRITE;
            WRITE: begin
                if (j_q == AW'(N_OUT - 1)) begin
                    state_d = DONE;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = CLEAR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            wptr_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            wptr_q  <= wptr_d;
        end
    end

    // Outputs are registered decodes of the next state, so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_addr_q  <= '0;
            w_addr_q   <= '0;
            out_addr_q <= '0;
            rd_en_q    <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            out_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (state_d == FETCH) begin
                in_addr_q <= i_d;
                w_addr_q  <= wptr_d;
            end
            if (state_d == WRITE) begin
                out_addr_q <= j_d;
            end
            rd_en_q   <= (state_d == FETCH);
            mac_clr_q <= (state_d == CLEAR);
            // One-cycle read latency; an abort also kills the in-flight accumulate.
            mac_en_q  <= rd_en_q && (state_d != IDLE);
            out_wr_q  <= (state_d == WRITE);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
        end
    end

    assign in_addr   = in_addr_q;
    assign w_addr    = w_addr_q;
    assign out_addr  = out_addr_q;
    assign rd_en     = rd_en_q;
    assign mac_clr   = mac_clr_q;
    assign mac_en    = mac_en_q;
    assign out_wr    = out_wr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Control sequencer for one fully-connected MLP layer. It walks every (neuron, input) pair in order and drives the read addresses of the input and weight memories. It also drives the clear and enable strobes of the MAC datapath and the write strobe and address of the layer-output buffer. It sits directly upstream of the MAC/accumulator and counter stages, which it steps, and downstream of the top-level network controller, which starts it per layer.

## Interface
- N_IN, default 8: inputs per neuron (≥1).
- N_OUT, default 4: neurons in the layer (≥1).
- AW, default 8: address width; must hold N_OUT*N_IN-1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. Single clock domain.
- start  in  1  level-sampled in IDLE; begins a layer pass.
- abort  in  1  synchronous cancel of a running pass.
- in_addr  out  AW  input-memory read address (input index i).
- w_addr  out  AW  weight-memory read address (running pointer j*N_IN+i).
- rd_en  out  1  memory read strobe.
- mac_clr  out  1  clears the accumulator.
- mac_en  out  1  accumulate strobe; read data is valid this cycle.
- out_addr  out  AW  neuron index j for the output write.
- out_wr  out  1  writes the activated accumulator to the output buffer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset puts the FSM in IDLE with i=j=wptr=0.
- States: IDLE, CLEAR, FETCH, DRAIN, WRITE, DONE.
- IDLE: all strobes 0. If start=1, go to CLEAR and reset j, i and wptr to 0.
- CLEAR: mac_clr=1 for one cycle. i=0. Next state FETCH.
- FETCH: rd_en=1, in_addr=i, w_addr=wptr. Each cycle i+1 and wptr+1.
  - When i==N_IN-1, go to DRAIN.
  - FETCH lasts exactly N_IN cycles.
- DRAIN: one cycle. rd_en=0. It exists only so the final mac_en occurs.
- WRITE: out_wr=1, out_addr=j.
  - If j==N_OUT-1, go to DONE.
  - Otherwise j+1 and go to CLEAR.
- DONE: done=1 for one cycle, busy still 1. Next state IDLE.
- mac_en is rd_en delayed by exactly one cycle, matching a 1-cycle memory read latency. So mac_en is high in the cycles FETCH(2..N_IN) and DRAIN, and 0 in CLEAR and WRITE.
- wptr is not reset between neurons. It runs 0..N_OUT*N_IN-1 continuously and never wraps within a pass.
- start while busy is ignored. start held high in IDLE after done begins a new pass.
- abort=1 in any non-IDLE state: next cycle goes to IDLE, all strobes 0, no done, no out_wr. abort in IDLE has no effect.
- abort and start high together in IDLE: start wins.
- rst_n low mid-pass: outputs drop to 0 immediately (asynchronous). On release, state is IDLE.

## Timing
- Edge k samples start=1 in IDLE. CLEAR occupies cycle k+1.
- Per neuron: 1 CLEAR + N_IN FETCH + 1 DRAIN + 1 WRITE = N_IN+3 cycles.
- done is asserted in cycle k+1+N_OUT*(N_IN+3). busy is high from cycle k+1 through the done cycle inclusive.
- Earliest next start is sampled in the first IDLE cycle after DONE.
- Neuron j's final mac_en (DRAIN) immediately precedes its out_wr (WRITE). The accumulator is stable for the whole WRITE cycle.
- N_IN=1 boundary: FETCH is a single cycle. mac_en is high only in DRAIN.

## Test plan
- Reset: assert rst_n=0 mid-FETCH, check all outputs 0 asynchronously. Release rst_n, pulse start -> full pass completes normally.
- Nominal, N_IN=3, N_OUT=2, start at edge 0:
  - CLEAR in cycles 1 and 7; FETCH in cycles 2–4 and 8–10.
  - w_addr sequence 0,1,2,3,4,5; in_addr sequence 0,1,2,0,1,2.
  - mac_en high in cycles 3–5 and 9–11.
  - out_wr in cycle 6 with out_addr=0, and in cycle 12 with out_addr=1.
  - done in cycle 13; busy high in cycles 1–13.
- Edge case N_IN=1, N_OUT=1: done in cycle 5. Exactly one rd_en (cycle 2), one mac_en (cycle 3) and one out_wr (cycle 4).
- start pulsed during FETCH -> no effect on the sequence or on done timing. start held high -> second pass's CLEAR follows the first IDLE cycle after done.
- abort asserted during neuron 1's FETCH -> next cycle IDLE, no further out_wr, done never pulses. A fresh start then restarts from w_addr=0 and out_addr=0.
- start and abort both high in IDLE -> pass begins. abort alone in IDLE -> remains IDLE.
